// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues RISC-V M-extension divide/remainder ops to a
// multi-cycle 64-bit divider. Divide-by-zero and signed overflow are resolved
// locally. Otherwise the divider handshake is driven with operands held stable,
// and the result is held until writeback takes it.
`timescale 1ns/1ps
module div_issue_ctrl #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_sel,
  input  logic              op_w,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] result,
  input  logic              div_ready,
  input  logic              div_out_valid,
  input  logic [DATA_W-1:0] div_quot,
  input  logic [DATA_W-1:0] div_rema,
  output logic              div_valid,
  output logic              div_signed,
  output logic              div_w,
  output logic              div_flush,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_e            state_q;
  logic [1:0]        op_sel_q;
  logic              op_w_q;
  logic [DATA_W-1:0] src1_q;
  logic [DATA_W-1:0] src2_q;
  logic [DATA_W-1:0] result_q;
  logic              res_valid_q;

  logic              accept;
  logic              b_zero;
  logic              s_ovf;
  logic [DATA_W-1:0] spec_res_d;
  logic [DATA_W-1:0] div_res_d;

  // W results are always the low word sign-extended, even for DIVUW/REMUW.
  function automatic logic [DATA_W-1:0] sext_w(input logic [31:0] v);
    return {{(DATA_W-32){v[31]}}, v};
  endfunction

  // Result of a locally resolved op: divide-by-zero or signed overflow.
  function automatic logic [DATA_W-1:0] special_result(
    input logic              is_rem,
    input logic              is_w,
    input logic [DATA_W-1:0] a,
    input logic              zero_div
  );
    logic [DATA_W-1:0] raw;
    if (zero_div) raw = is_rem ? a : '1;
    else          raw = is_rem ? '0 : a;
    return is_w ? sext_w(raw[31:0]) : raw;
  endfunction

  // Accept only when idle, the divider is idle and nothing is being flushed.
  // While reset is held, op_ready is forced low as well.
  always_comb begin
    op_ready = reset & (state_q == S_IDLE) & div_ready & ~flush;
    accept   = op_valid & op_ready;
  end

  // Special-case detection on the effective operand width of the incoming op.
  always_comb begin
    b_zero     = op_w ? (src2[31:0] == 32'd0) : (src2 == '0);
    s_ovf      = ~op_sel[0] & (op_w ? ((src1[31:0] == 32'h8000_0000) && (&src2[31:0]))
                                    : ((src1 == MOST_NEG) && (&src2)));
    spec_res_d = special_result(op_sel[1], op_w, src1, b_zero);
    div_res_d  = op_sel_q[1] ? div_rema : div_quot;
    if (op_w_q) div_res_d = sext_w(div_res_d[31:0]);
  end

  // Divider request is live only in WAIT, so the divider never restarts on its own.
  always_comb begin
    div_valid    = (state_q == S_WAIT);
    div_signed   = div_valid & ~op_sel_q[0];
    div_w        = div_valid & op_w_q;
    div_flush    = flush;
    div_dividend = src1_q;
    div_divisor  = src2_q;
    res_valid    = res_valid_q;
    result       = result_q;
  end

  // Control FSM with op capture and registered result; flush wins over everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_sel_q    <= 2'b00;
      op_w_q      <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_sel_q <= op_sel;
            op_w_q   <= op_w;
            src1_q   <= src1;
            src2_q   <= src2;
            if (b_zero || s_ovf) begin
              result_q    <= spec_res_d;
              res_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (div_out_valid) begin
            result_q    <= div_res_d;
            res_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed testbench for div_issue_ctrl; the bench plays the divider by hand.
`timescale 1ns/1ps
module tb_div_issue_ctrl;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              op_valid;
  logic              op_ready;
  logic [1:0]        op_sel;
  logic              op_w;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] result;
  logic              div_ready;
  logic              div_out_valid;
  logic [DATA_W-1:0] div_quot;
  logic [DATA_W-1:0] div_rema;
  logic              div_valid;
  logic              div_signed;
  logic              div_w;
  logic              div_flush;
  logic [DATA_W-1:0] div_dividend;
  logic [DATA_W-1:0] div_divisor;

  int tests = 0;
  int fails = 0;

  div_issue_ctrl #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .op_valid(op_valid), .op_ready(op_ready), .op_sel(op_sel), .op_w(op_w),
    .src1(src1), .src2(src2),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .div_ready(div_ready), .div_out_valid(div_out_valid),
    .div_quot(div_quot), .div_rema(div_rema),
    .div_valid(div_valid), .div_signed(div_signed), .div_w(div_w),
    .div_flush(div_flush), .div_dividend(div_dividend), .div_divisor(div_divisor)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; op_valid = 1'b1; op_sel = 2'b01; op_w = 1'b0;
    src1 = 64'd9; src2 = 64'd3; res_ready = 1'b0; div_ready = 1'b1;
    div_out_valid = 1'b0; div_quot = '0; div_rema = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
      tests++; if (div_valid !== 1'b0) begin fails++; $display("FAIL reset_div_valid got=%b want=0", div_valid); end
      tests++; if (result !== '0) begin fails++; $display("FAIL reset_result got=%h want=0", result); end
      tests++; if (op_ready !== 1'b0) begin fails++; $display("FAIL reset_op_ready got=%b want=0", op_ready); end
    end
    @(negedge clk);
    op_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk); #1;
    tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL post_reset_op_ready got=%b want=1", op_ready); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL post_reset_res_valid got=%b want=0", res_valid); end
  endtask

  task automatic test_normal_ops();
    logic [1:0]        v_sel;
    logic              v_w;
    logic [DATA_W-1:0] v_a, v_b, v_q, v_r, v_exp, mask;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin v_sel = 2'b00; v_w = 1'b0; v_a = 64'hFFFF_FFFF_FFFF_FFF9; v_b = 64'd2;
                 v_q = 64'hFFFF_FFFF_FFFF_FFFD; v_r = 64'hFFFF_FFFF_FFFF_FFFF; v_exp = 64'hFFFF_FFFF_FFFF_FFFD; end
        1: begin v_sel = 2'b10; v_w = 1'b0; v_a = 64'hFFFF_FFFF_FFFF_FFF9; v_b = 64'd2;
                 v_q = 64'hFFFF_FFFF_FFFF_FFFD; v_r = 64'hFFFF_FFFF_FFFF_FFFF; v_exp = 64'hFFFF_FFFF_FFFF_FFFF; end
        2: begin v_sel = 2'b01; v_w = 1'b1; v_a = 64'h0000_0000_8000_0000; v_b = 64'd1;
                 v_q = 64'h0000_0000_8000_0000; v_r = 64'd0; v_exp = 64'hFFFF_FFFF_8000_0000; end
        default: begin v_sel = 2'b10; v_w = 1'b1; v_a = 64'h0000_0001_0000_0005; v_b = 64'd3;
                 v_q = 64'd1; v_r = 64'd2; v_exp = 64'd2; end
      endcase
      mask = v_w ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      op_valid = 1'b1; op_sel = v_sel; op_w = v_w; src1 = v_a; src2 = v_b;
      #1;
      tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL norm%0d_op_ready got=%b want=1", i, op_ready); end
      @(negedge clk);
      op_valid = 1'b0; src1 = '0; src2 = '0;
      #1;
      tests++; if (div_signed !== ~v_sel[0]) begin fails++; $display("FAIL norm%0d_div_signed got=%b want=%b", i, div_signed, ~v_sel[0]); end
      tests++; if (div_w !== v_w) begin fails++; $display("FAIL norm%0d_div_w got=%b want=%b", i, div_w, v_w); end
      for (int k = 0; k < 4; k++) begin
        if (k == 3) begin div_out_valid = 1'b1; div_quot = v_q; div_rema = v_r; #1; end
        tests++; if (div_valid !== 1'b1) begin fails++; $display("FAIL norm%0d_div_valid_c%0d got=%b want=1", i, k, div_valid); end
        tests++; if ((div_dividend & mask) !== (v_a & mask)) begin fails++; $display("FAIL norm%0d_dividend_c%0d got=%h want=%h", i, k, div_dividend, v_a); end
        tests++; if ((div_divisor & mask) !== (v_b & mask)) begin fails++; $display("FAIL norm%0d_divisor_c%0d got=%h want=%h", i, k, div_divisor, v_b); end
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL norm%0d_early_res_valid_c%0d got=%b want=0", i, k, res_valid); end
        if (k < 3) @(negedge clk);
      end
      @(negedge clk);
      div_out_valid = 1'b0; div_quot = '0; div_rema = '0;
      #1;
      tests++; if (div_valid !== 1'b0) begin fails++; $display("FAIL norm%0d_div_valid_after got=%b want=0", i, div_valid); end
      tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL norm%0d_res_valid got=%b want=1", i, res_valid); end
      tests++; if (result !== v_exp) begin fails++; $display("FAIL norm%0d_result got=%h want=%h", i, result, v_exp); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      #1;
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL norm%0d_res_drop got=%b want=0", i, res_valid); end
    end
  endtask

  task automatic test_special_cases();
    logic [1:0]        v_sel;
    logic              v_w;
    logic [DATA_W-1:0] v_a, v_b, v_exp;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin v_sel = 2'b01; v_w = 1'b0; v_a = 64'd123; v_b = 64'd0; v_exp = 64'hFFFF_FFFF_FFFF_FFFF; end
        1: begin v_sel = 2'b11; v_w = 1'b0; v_a = 64'd123; v_b = 64'd0; v_exp = 64'd123; end
        2: begin v_sel = 2'b00; v_w = 1'b0; v_a = 64'h8000_0000_0000_0000; v_b = 64'hFFFF_FFFF_FFFF_FFFF;
                 v_exp = 64'h8000_0000_0000_0000; end
        3: begin v_sel = 2'b10; v_w = 1'b1; v_a = 64'h0000_0000_8000_0000; v_b = 64'hFFFF_FFFF_FFFF_FFFF; v_exp = 64'd0; end
        4: begin v_sel = 2'b00; v_w = 1'b1; v_a = 64'h0000_0000_8000_0000; v_b = 64'h0000_0000_FFFF_FFFF;
                 v_exp = 64'hFFFF_FFFF_8000_0000; end
        5: begin v_sel = 2'b01; v_w = 1'b1; v_a = 64'd5; v_b = 64'h0000_0001_0000_0000; v_exp = 64'hFFFF_FFFF_FFFF_FFFF; end
        default: begin v_sel = 2'b11; v_w = 1'b1; v_a = 64'h0000_0001_8000_0007; v_b = 64'h0000_0002_0000_0000;
                 v_exp = 64'hFFFF_FFFF_8000_0007; end
      endcase
      @(negedge clk);
      op_valid = 1'b1; op_sel = v_sel; op_w = v_w; src1 = v_a; src2 = v_b;
      #1;
      tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL spec%0d_op_ready got=%b want=1", i, op_ready); end
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      tests++; if (div_valid !== 1'b0) begin fails++; $display("FAIL spec%0d_div_valid got=%b want=0", i, div_valid); end
      tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL spec%0d_res_valid got=%b want=1", i, res_valid); end
      tests++; if (result !== v_exp) begin fails++; $display("FAIL spec%0d_result got=%h want=%h", i, result, v_exp); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      #1;
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL spec%0d_res_drop got=%b want=0", i, res_valid); end
    end
  endtask

  task automatic test_flush();
    // Flush ten cycles into WAIT
    @(negedge clk);
    op_valid = 1'b1; op_sel = 2'b00; op_w = 1'b0; src1 = 64'd1000; src2 = 64'd9;
    @(negedge clk);
    op_valid = 1'b0;
    div_ready = 1'b0;
    for (int k = 0; k < 9; k++) @(negedge clk);
    #1;
    tests++; if (div_valid !== 1'b1) begin fails++; $display("FAIL flush_pre_div_valid got=%b want=1", div_valid); end
    flush = 1'b1;
    #1;
    tests++; if (div_flush !== 1'b1) begin fails++; $display("FAIL flush_div_flush got=%b want=1", div_flush); end
    @(negedge clk);
    flush = 1'b0;
    op_valid = 1'b1; op_sel = 2'b01; op_w = 1'b0; src1 = 64'd100; src2 = 64'd7;
    #1;
    tests++; if (div_flush !== 1'b0) begin fails++; $display("FAIL flush_div_flush_drop got=%b want=0", div_flush); end
    for (int k = 0; k < 4; k++) begin
      div_out_valid = (k == 1);
      div_quot = 64'd111;
      #1;
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL flush_res_valid_c%0d got=%b want=0", k, res_valid); end
      tests++; if (div_valid !== 1'b0) begin fails++; $display("FAIL flush_div_valid_c%0d got=%b want=0", k, div_valid); end
      tests++; if (op_ready !== 1'b0) begin fails++; $display("FAIL flush_op_ready_c%0d got=%b want=0", k, op_ready); end
      @(negedge clk);
    end
    div_out_valid = 1'b0;
    div_ready = 1'b1;
    #1;
    tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL flush_op_ready_return got=%b want=1", op_ready); end
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    tests++; if (div_valid !== 1'b1) begin fails++; $display("FAIL divu_div_valid got=%b want=1", div_valid); end
    tests++; if (div_dividend !== 64'd100) begin fails++; $display("FAIL divu_dividend got=%h want=%h", div_dividend, 64'd100); end
    tests++; if (div_signed !== 1'b0) begin fails++; $display("FAIL divu_div_signed got=%b want=0", div_signed); end
    @(negedge clk);
    div_out_valid = 1'b1; div_quot = 64'd14; div_rema = 64'd2;
    @(negedge clk);
    div_out_valid = 1'b0;
    #1;
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL divu_res_valid got=%b want=1", res_valid); end
    tests++; if (result !== 64'd14) begin fails++; $display("FAIL divu_result got=%h want=%h", result, 64'd14); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    // Flush and div_out_valid in the same cycle: flush wins
    op_valid = 1'b1; op_sel = 2'b00; op_w = 1'b0; src1 = 64'd20; src2 = 64'd3;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1; div_out_valid = 1'b1; div_quot = 64'd6; div_rema = 64'd2;
    @(negedge clk);
    flush = 1'b0; div_out_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL flush_prio_res_valid_c%0d got=%b want=0", k, res_valid); end
      tests++; if (div_valid !== 1'b0) begin fails++; $display("FAIL flush_prio_div_valid_c%0d got=%b want=0", k, div_valid); end
      @(negedge clk);
    end
    // Flush while the result is held
    op_valid = 1'b1; op_sel = 2'b01; op_w = 1'b0; src1 = 64'd50; src2 = 64'd0;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL flush_resp_pre got=%b want=1", res_valid); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL flush_resp_drop got=%b want=0", res_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    op_valid = 1'b1; op_sel = 2'b01; op_w = 1'b0; src1 = 64'd123; src2 = 64'd0;
    @(negedge clk);
    op_sel = 2'b11; src1 = 64'd77; src2 = 64'd5;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL bp_res_valid_c%0d got=%b want=1", k, res_valid); end
      tests++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL bp_result_c%0d got=%h want=%h", k, result, 64'hFFFF_FFFF_FFFF_FFFF); end
      tests++; if (op_ready !== 1'b0) begin fails++; $display("FAIL bp_op_ready_c%0d got=%b want=0", k, op_ready); end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL bp_release_res_valid got=%b want=0", res_valid); end
    tests++; if (div_valid !== 1'b0) begin fails++; $display("FAIL bp_release_no_accept got=%b want=0", div_valid); end
    tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL bp_release_op_ready got=%b want=1", op_ready); end
    op_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_normal_ops();
    test_special_cases();
    test_flush();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Initiator-side controller between the EXE stage and the multi-cycle 64-bit radix-2 divider. It accepts a RISC-V M-extension divide/remainder op, resolves divide-by-zero and signed overflow locally, and otherwise drives the divider's valid/signed/word handshake with operands held stable. It then selects quotient or remainder, sign-extends W results, and holds the result until writeback accepts it.

Parameters:
DATA_W, 64, operand/result width; the divider interface is fixed at 64.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
flush  in  1  pipeline flush; cancels the in-flight op
op_valid  in  1  EXE presents an op
op_ready  out  1  controller can accept an op
op_sel  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
op_w  in  1  32-bit (W) variant
src1  in  DATA_W  dividend
src2  in  DATA_W  divisor
res_valid  out  1  result available
res_ready  in  1  writeback accepts result
result  out  DATA_W  final rd value
div_ready  in  1  divider idle
div_out_valid  in  1  divider result valid
div_quot  in  DATA_W  divider quotient
div_rema  in  DATA_W  divider remainder
div_valid  out  1  request to divider
div_signed  out  1  signed divide
div_w  out  1  32-bit divide
div_flush  out  1  cancel to divider
div_dividend  out  DATA_W  operand A
div_divisor  out  DATA_W  operand B

Behaviour:
- Reset (reset low, asynchronous): state IDLE, res_valid 0, result 0, operand/op registers 0. All div_* outputs are 0.
- States:
  - IDLE: waiting for an op.
  - WAIT: divider running.
  - RESP: result held.
- op_ready = (state==IDLE) & div_ready & ~flush. An op is accepted when op_valid & op_ready.
- On accept, register op_sel, op_w, src1, src2. Operand width is the low 32 bits if op_w, else the full 64 bits.
- Special cases, checked at accept on the effective width. These go directly to RESP next cycle, with no divider request.
  - Divisor zero: quotient is all ones; remainder is the dividend.
  - Signed op (DIV/REM) with dividend = most-negative and divisor = -1: quotient is the dividend; remainder is 0.
- Otherwise go to WAIT.
- In WAIT:
  - div_valid = 1.
  - div_signed = ~op_sel[0].
  - div_w = op_w.
  - div_dividend and div_divisor come from the registered operands. For W ops, the upper 32 bits are don't-care.
  - div_valid and all operands stay constant through the div_out_valid cycle inclusive. The divider derives result signs combinationally from them.
  - div_valid is 0 in every other state, so the divider returns to idle and does not restart.
- WAIT exit: on div_out_valid, capture result = op_sel[1] ? div_rema : div_quot and go to RESP.
- W result: result = sign-extend of bit 31 of the selected 32-bit value, for all W ops including DIVUW/REMUW.
- RESP:
  - res_valid = 1 and result is stable.
  - On res_ready, go to IDLE. An op may not be accepted in that same cycle.
- Latency:
  - Special case: res_valid the cycle after accept.
  - Normal: res_valid the cycle after div_out_valid.
- Flush, in any state:
  - div_flush = flush, combinational.
  - Next state IDLE; res_valid drops next cycle with no result delivered.
  - A flushed op never produces res_valid.
  - The divider's FSM keeps running after its flush. A new op is blocked until div_ready returns high.
- div_out_valid seen outside WAIT is ignored.
- flush has priority over res_ready and div_out_valid in the same cycle.
- Reset deasserting mid-operation leaves the state at IDLE. Any pending op is lost.

Test Plan:
- Reset: hold reset low 3 cycles with op_valid high -> res_valid 0, div_valid 0, result 0, op_ready 0 while reset is low.
- DIV -7/2 (src1=0xFFFF_FFFF_FFFF_FFF9, src2=2): div_valid stays high with constant operands until div_out_valid, then low. Next cycle res_valid, result=0xFFFF_FFFF_FFFF_FFFD. The same operands with REM give 0xFFFF_FFFF_FFFF_FFFF.
- DIVUW src1=0x0000_0000_8000_0000, src2=1 -> result 0xFFFF_FFFF_8000_0000. REMW src1=0x1_0000_0005, src2=3 -> result 2.
- DIVU by zero, src1=123, src2=0 -> res_valid 1 cycle after accept, result all ones, div_valid never set. REMU by zero -> 123. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REMW 0x8000_0000 / -1 -> 0.
- Flush 10 cycles into WAIT: div_flush pulses, no res_valid, and op_ready stays 0 until div_ready returns. A following DIVU 100/7 yields 14.
- Backpressure: hold res_ready low 5 cycles in RESP -> result and res_valid stable, op_ready 0. Release -> IDLE next cycle.
